// File: rtl/gba_line_cache.sv
// Line store between GBA capture and the HDMI image generator: a ring of four
// line buffers with a registered 3x3 neighbourhood read port and the
// sameLine / newFrameOut pacing signals.
module gba_line_cache #(
   parameter int LINE_PIXELS = 240,
   parameter int FRAME_LINES = 160
) (
   input  logic        pxlClk,
   input  logic        rst,
   input  logic        wrValid,
   input  logic        wrNewFrame,
   input  logic [23:0] wrRgb,
   input  logic        nextLine,
   input  logic        cacheUpdate,
   input  logic [7:0]  curPxl,
   output logic [23:0] prevLinePrevPxl,
   output logic [23:0] prevLineCurPxl,
   output logic [23:0] prevLineNextPxl,
   output logic [23:0] curLinePrevPxl,
   output logic [23:0] curLineCurPxl,
   output logic [23:0] curLineNextPxl,
   output logic [23:0] nextLinePrevPxl,
   output logic [23:0] nextLineCurPxl,
   output logic [23:0] nextLineNextPxl,
   output logic        sameLine,
   output logic        newFrameOut,
   output logic        overrunErr
);

   localparam int LW = $clog2(FRAME_LINES + 1);
   localparam logic [7:0]    LAST_COL   = 8'(LINE_PIXELS - 1);
   localparam logic [LW-1:0] LAST_LINE  = LW'(FRAME_LINES - 1);
   localparam logic [LW-1:0] FRAME_DONE = LW'(FRAME_LINES);

   logic [23:0] line_mem [4][LINE_PIXELS];

   logic [7:0]    wr_col, col_eff, col_next;
   logic [LW-1:0] wr_line, line_eff, line_next;
   logic [LW-1:0] lines_done, done_eff, done_next;
   logic [1:0]    wr_buf, buf_eff, buf_next;
   logic [3:0]    buf_valid;
   logic          start, accept, line_end, overrun_hit;

   logic [LW-1:0] rd_line, line_p, line_n;
   logic          pending, nf_prev, nf_rise;
   logic [7:0]    col_c, col_p, col_n;
   logic [1:0]    buf_p, buf_c, buf_n;
   logic [LW:0]   rd_plus2, need;

   // A buffer only becomes readable once a full line has landed in it, so
   // stale contents left over from before a reset are never shown.
   function automatic logic [23:0] fetch(input logic [1:0] b, input logic [7:0] c);
      return buf_valid[b] ? line_mem[b][c] : 24'd0;
   endfunction

   // Writer next-state: frame start forces the pointers to zero before this
   // pixel is stored, and pixels past the last line are dropped.
   always_comb begin
      start    = wrValid & wrNewFrame;
      col_eff  = start ? 8'd0 : wr_col;
      line_eff = start ? '0 : wr_line;
      done_eff = start ? '0 : lines_done;
      buf_eff  = start ? 2'd0 : wr_buf;
      accept   = wrValid & (start | (lines_done != FRAME_DONE));
      line_end = accept & (col_eff == LAST_COL);
      col_next  = wr_col;
      line_next = wr_line;
      done_next = lines_done;
      buf_next  = wr_buf;
      if (accept) begin
         if (line_end) begin
            col_next  = 8'd0;
            line_next = (line_eff == LAST_LINE) ? line_eff : line_eff + 1'b1;
            done_next = (done_eff == FRAME_DONE) ? done_eff : done_eff + 1'b1;
            buf_next  = buf_eff + 2'd1;
         end else begin
            col_next  = col_eff + 8'd1;
            line_next = line_eff;
            done_next = done_eff;
            buf_next  = buf_eff;
         end
      end
      overrun_hit = line_end &
                    ({1'b0, done_next} > ({1'b0, rd_line} + (LW+1)'(3)));
   end

   // Writer pointer, completed-line bookkeeping and the sticky overrun flag.
   always_ff @(posedge pxlClk) begin
      if (rst) begin
         wr_col     <= 8'd0;
         wr_line    <= '0;
         lines_done <= '0;
         wr_buf     <= 2'd0;
         buf_valid  <= 4'd0;
         overrunErr <= 1'b0;
      end else begin
         wr_col     <= col_next;
         wr_line    <= line_next;
         lines_done <= done_next;
         wr_buf     <= buf_next;
         if (line_end) buf_valid[buf_eff] <= 1'b1;
         if (overrun_hit) overrunErr <= 1'b1;
      end
   end

   // Pixel storage; a same-cycle read of this address still sees old data.
   always_ff @(posedge pxlClk) begin
      if (accept && !rst) line_mem[buf_eff][col_eff] <= wrRgb;
   end

   // The reader must resync while the second line of a new frame is filling.
   assign newFrameOut = (lines_done == LW'(1));
   assign nf_rise     = newFrameOut & ~nf_prev;

   // Reader line: a requested advance waits for the line-end strobe, and a
   // frame resync overrides any advance in the same cycle.
   always_ff @(posedge pxlClk) begin
      if (rst) begin
         rd_line <= '0;
         pending <= 1'b0;
         nf_prev <= 1'b0;
      end else begin
         nf_prev <= newFrameOut;
         if (nf_rise) begin
            rd_line <= '0;
            pending <= 1'b0;
         end else if (cacheUpdate && (pending || nextLine)) begin
            rd_line <= (rd_line == LAST_LINE) ? rd_line : rd_line + 1'b1;
            pending <= 1'b0;
         end else if (nextLine) begin
            pending <= 1'b1;
         end
      end
   end

   // Window coordinates with edge replication on both axes.
   always_comb begin
      col_c  = (curPxl > LAST_COL) ? LAST_COL : curPxl;
      col_p  = (col_c == 8'd0) ? 8'd0 : col_c - 8'd1;
      col_n  = (col_c == LAST_COL) ? col_c : col_c + 8'd1;
      line_p = (rd_line == '0) ? rd_line : rd_line - 1'b1;
      line_n = (rd_line == LAST_LINE) ? rd_line : rd_line + 1'b1;
      buf_p  = line_p[1:0];
      buf_c  = rd_line[1:0];
      buf_n  = line_n[1:0];
   end

   // Registered 3x3 window, one cycle behind curPxl.
   always_ff @(posedge pxlClk) begin
      if (rst) begin
         prevLinePrevPxl <= 24'd0;
         prevLineCurPxl  <= 24'd0;
         prevLineNextPxl <= 24'd0;
         curLinePrevPxl  <= 24'd0;
         curLineCurPxl   <= 24'd0;
         curLineNextPxl  <= 24'd0;
         nextLinePrevPxl <= 24'd0;
         nextLineCurPxl  <= 24'd0;
         nextLineNextPxl <= 24'd0;
      end else begin
         prevLinePrevPxl <= fetch(buf_p, col_p);
         prevLineCurPxl  <= fetch(buf_p, col_c);
         prevLineNextPxl <= fetch(buf_p, col_n);
         curLinePrevPxl  <= fetch(buf_c, col_p);
         curLineCurPxl   <= fetch(buf_c, col_c);
         curLineNextPxl  <= fetch(buf_c, col_n);
         nextLinePrevPxl <= fetch(buf_n, col_p);
         nextLineCurPxl  <= fetch(buf_n, col_c);
         nextLineNextPxl <= fetch(buf_n, col_n);
      end
   end

   // Advancing is unsafe until the line two ahead of the reader is complete.
   always_comb begin
      rd_plus2 = {1'b0, rd_line} + (LW+1)'(2);
      need     = (rd_plus2 > {1'b0, LAST_LINE}) ? {1'b0, LAST_LINE} : rd_plus2;
      sameLine = ({1'b0, lines_done} <= need) | (rd_line == LAST_LINE);
   end

endmodule

// File: tb/tb_gba_line_cache.sv
// Directed self-checking bench for gba_line_cache.
module tb_gba_line_cache;

   logic        pxlClk = 1'b0;
   logic        rst = 1'b1;
   logic        wrValid = 1'b0;
   logic        wrNewFrame = 1'b0;
   logic [23:0] wrRgb = 24'd0;
   logic        nextLine = 1'b0;
   logic        cacheUpdate = 1'b0;
   logic [7:0]  curPxl = 8'd0;
   logic [23:0] prevLinePrevPxl, prevLineCurPxl, prevLineNextPxl;
   logic [23:0] curLinePrevPxl, curLineCurPxl, curLineNextPxl;
   logic [23:0] nextLinePrevPxl, nextLineCurPxl, nextLineNextPxl;
   logic        sameLine, newFrameOut, overrunErr;
   logic [23:0] win [9];

   int total = 0;
   int bad = 0;
   int nfCount = 0;

   gba_line_cache dut (
      .pxlClk(pxlClk), .rst(rst), .wrValid(wrValid), .wrNewFrame(wrNewFrame),
      .wrRgb(wrRgb), .nextLine(nextLine), .cacheUpdate(cacheUpdate), .curPxl(curPxl),
      .prevLinePrevPxl(prevLinePrevPxl), .prevLineCurPxl(prevLineCurPxl),
      .prevLineNextPxl(prevLineNextPxl), .curLinePrevPxl(curLinePrevPxl),
      .curLineCurPxl(curLineCurPxl), .curLineNextPxl(curLineNextPxl),
      .nextLinePrevPxl(nextLinePrevPxl), .nextLineCurPxl(nextLineCurPxl),
      .nextLineNextPxl(nextLineNextPxl), .sameLine(sameLine),
      .newFrameOut(newFrameOut), .overrunErr(overrunErr)
   );

   always #5 pxlClk = ~pxlClk;

   assign win[0] = prevLinePrevPxl;
   assign win[1] = prevLineCurPxl;
   assign win[2] = prevLineNextPxl;
   assign win[3] = curLinePrevPxl;
   assign win[4] = curLineCurPxl;
   assign win[5] = curLineNextPxl;
   assign win[6] = nextLinePrevPxl;
   assign win[7] = nextLineCurPxl;
   assign win[8] = nextLineNextPxl;

   // Expected pixel (line<<8 | col) at window slot (li,pi) with edge clamping.
   function automatic logic [23:0] expWin(input int rd, input int px, input int li, input int pi);
      int c, l, cc;
      c  = (px > 239) ? 239 : px;
      l  = rd + li - 1;
      cc = c + pi - 1;
      if (l < 0) l = 0;
      if (l > 159) l = 159;
      if (cc < 0) cc = 0;
      if (cc > 239) cc = 239;
      return {8'h00, l[7:0], cc[7:0]};
   endfunction

   // Stream count pixels of one line, counting beats seen with newFrameOut high.
   task automatic applyStimulus(input int line, input int count, input bit nf);
      for (int c = 0; c < count; c++) begin
         @(negedge pxlClk);
         wrValid    = 1'b1;
         wrNewFrame = nf && (c == 0);
         wrRgb      = {8'h00, 8'(line), 8'(c)};
         if (newFrameOut) nfCount++;
      end
      @(negedge pxlClk);
      wrValid    = 1'b0;
      wrNewFrame = 1'b0;
   endtask

   task automatic advanceReader();
      @(negedge pxlClk);
      nextLine    = 1'b1;
      cacheUpdate = 1'b1;
      @(negedge pxlClk);
      nextLine    = 1'b0;
      cacheUpdate = 1'b0;
   endtask

   task automatic setPxl(input int v);
      @(negedge pxlClk);
      curPxl = 8'(v);
      @(negedge pxlClk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge pxlClk);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         total++;
         if (win[i] !== 24'd0) begin
            bad++;
            $display("[TB] FAIL reset_win%0d got=%h want=000000", i, win[i]);
         end
      end
      total++;
      if (sameLine !== 1'b1) begin bad++; $display("[TB] FAIL reset_sameLine got=%b want=1", sameLine); end
      total++;
      if (newFrameOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_newFrameOut got=%b want=0", newFrameOut); end
      total++;
      if (overrunErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrunErr got=%b want=0", overrunErr); end
   endtask

   task automatic test_new_frame();
      nfCount = 0;
      applyStimulus(0, 240, 1'b1);
      total++;
      if (sameLine !== 1'b1) begin bad++; $display("[TB] FAIL nf_sameLine_l0 got=%b want=1", sameLine); end
      applyStimulus(1, 240, 1'b0);
      total++;
      if (nfCount !== 240) begin bad++; $display("[TB] FAIL nf_pulse_len got=%0d want=240", nfCount); end
      total++;
      if (newFrameOut !== 1'b0) begin bad++; $display("[TB] FAIL nf_after got=%b want=0", newFrameOut); end
      total++;
      if (sameLine !== 1'b1) begin bad++; $display("[TB] FAIL nf_sameLine_l1 got=%b want=1", sameLine); end
      setPxl(0);
      for (int i = 0; i < 9; i++) begin
         total++;
         if (win[i] !== expWin(0, 0, i / 3, i % 3)) begin
            bad++;
            $display("[TB] FAIL top_edge_win%0d got=%h want=%h", i, win[i], expWin(0, 0, i / 3, i % 3));
         end
      end
      applyStimulus(2, 240, 1'b0);
      total++;
      if (sameLine !== 1'b0) begin bad++; $display("[TB] FAIL nf_sameLine_l2 got=%b want=0", sameLine); end
   endtask

   task automatic test_window();
      advanceReader();
      for (int k = 3; k <= 6; k++) begin
         applyStimulus(k, 240, 1'b0);
         advanceReader();
      end
      setPxl(10);
      for (int i = 0; i < 9; i++) begin
         total++;
         if (win[i] !== expWin(5, 10, i / 3, i % 3)) begin
            bad++;
            $display("[TB] FAIL window_win%0d got=%h want=%h", i, win[i], expWin(5, 10, i / 3, i % 3));
         end
      end
      total++;
      if (curLineCurPxl !== 24'h00050A) begin bad++; $display("[TB] FAIL window_center got=%h want=00050a", curLineCurPxl); end
      total++;
      if (overrunErr !== 1'b0) begin bad++; $display("[TB] FAIL window_overrun got=%b want=0", overrunErr); end
   endtask

   task automatic test_hold_advance();
      applyStimulus(7, 240, 1'b0);
      @(negedge pxlClk);
      nextLine = 1'b1;
      @(negedge pxlClk);
      nextLine = 1'b0;
      repeat (2) @(negedge pxlClk);
      total++;
      if (curLineCurPxl !== 24'h00050A) begin bad++; $display("[TB] FAIL hold_pending got=%h want=00050a", curLineCurPxl); end
      cacheUpdate = 1'b1;
      @(negedge pxlClk);
      cacheUpdate = 1'b0;
      total++;
      if (curLineCurPxl !== 24'h00050A) begin bad++; $display("[TB] FAIL hold_same_edge got=%h want=00050a", curLineCurPxl); end
      @(negedge pxlClk);
      for (int i = 0; i < 9; i++) begin
         total++;
         if (win[i] !== expWin(6, 10, i / 3, i % 3)) begin
            bad++;
            $display("[TB] FAIL hold_applied_win%0d got=%h want=%h", i, win[i], expWin(6, 10, i / 3, i % 3));
         end
      end
   endtask

   task automatic test_frame_end();
      for (int k = 8; k <= 159; k++) begin
         applyStimulus(k, 240, 1'b0);
         advanceReader();
      end
      advanceReader();
      advanceReader();
      setPxl(239);
      for (int i = 0; i < 9; i++) begin
         total++;
         if (win[i] !== expWin(159, 239, i / 3, i % 3)) begin
            bad++;
            $display("[TB] FAIL bottom_edge_win%0d got=%h want=%h", i, win[i], expWin(159, 239, i / 3, i % 3));
         end
      end
      total++;
      if (sameLine !== 1'b1) begin bad++; $display("[TB] FAIL bottom_sameLine got=%b want=1", sameLine); end
      setPxl(250);
      total++;
      if (curLinePrevPxl !== 24'h009FEE) begin bad++; $display("[TB] FAIL clamp_prev got=%h want=009fee", curLinePrevPxl); end
      total++;
      if (nextLineNextPxl !== 24'h009FEF) begin bad++; $display("[TB] FAIL clamp_next got=%h want=009fef", nextLineNextPxl); end
   endtask

   task automatic test_overrun();
      nfCount = 0;
      applyStimulus(0, 240, 1'b1);
      applyStimulus(1, 240, 1'b0);
      total++;
      if (nfCount !== 240) begin bad++; $display("[TB] FAIL ov_pulse_len got=%0d want=240", nfCount); end
      setPxl(5);
      total++;
      if (curLineCurPxl !== 24'h000005) begin bad++; $display("[TB] FAIL resync_cur got=%h want=000005", curLineCurPxl); end
      total++;
      if (nextLineCurPxl !== 24'h000105) begin bad++; $display("[TB] FAIL resync_next got=%h want=000105", nextLineCurPxl); end
      applyStimulus(2, 240, 1'b0);
      total++;
      if (overrunErr !== 1'b0) begin bad++; $display("[TB] FAIL ov_early got=%b want=0", overrunErr); end
      applyStimulus(3, 240, 1'b0);
      total++;
      if (overrunErr !== 1'b1) begin bad++; $display("[TB] FAIL ov_set got=%b want=1", overrunErr); end
      applyStimulus(4, 240, 1'b0);
      total++;
      if (overrunErr !== 1'b1) begin bad++; $display("[TB] FAIL ov_sticky got=%b want=1", overrunErr); end
   endtask

   task automatic test_reset_mid_line();
      for (int k = 5; k <= 36; k++) applyStimulus(k, 240, 1'b0);
      applyStimulus(37, 100, 1'b0);
      @(negedge pxlClk);
      rst    = 1'b1;
      curPxl = 8'd3;
      @(negedge pxlClk);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         total++;
         if (win[i] !== 24'd0) begin
            bad++;
            $display("[TB] FAIL midrst_win%0d got=%h want=000000", i, win[i]);
         end
      end
      total++;
      if (sameLine !== 1'b1) begin bad++; $display("[TB] FAIL midrst_sameLine got=%b want=1", sameLine); end
      total++;
      if (overrunErr !== 1'b0) begin bad++; $display("[TB] FAIL midrst_overrun got=%b want=0", overrunErr); end
      @(negedge pxlClk);
      total++;
      if (curLineCurPxl !== 24'd0) begin bad++; $display("[TB] FAIL midrst_stale got=%h want=000000", curLineCurPxl); end
      applyStimulus(0, 240, 1'b1);
      applyStimulus(1, 240, 1'b0);
      setPxl(3);
      for (int i = 0; i < 9; i++) begin
         total++;
         if (win[i] !== expWin(0, 3, i / 3, i % 3)) begin
            bad++;
            $display("[TB] FAIL restart_win%0d got=%h want=%h", i, win[i], expWin(0, 3, i / 3, i % 3));
         end
      end
   endtask

   // Scenario sequence; each scenario builds on the buffer state left by the previous one.
   initial begin
      $display("[TB] starting gba_line_cache bench");
      test_reset();
      test_new_frame();
      test_window();
      test_hold_advance();
      test_frame_end();
      test_overrun();
      test_reset_mid_line();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
